fmul_byte_bridge: RTL and testbench
===================================

// Module: fmul_byte_bridge
// PURPOSE
//  Host-side driver for the float Multiply core on a byte-wide pin interface.
//  - Collects two WIDTH-bit operands from strobed input bytes.
//  - Issues them to the multiplier and captures its result.
//  - Streams the result back out a byte at a time.
//  Sits between tt_um_* pins (ui_in/uo_out/uio) and the Multiply instance, replacing hardwired operands.
// PARAMETERS
//  WIDTH        32   operand/result width; must be a multiple of 8 (NBYTES = WIDTH/8)
//  TIMEOUT      255  max cycles spent in WAIT before flagging err; must be >= 1
//  SYNC_STAGES  2    synchronizer flops on in_strobe; must be >= 2
// PORTS
//  clk            in   1      single clock
//  rst_n          in   1      asynchronous, active-low reset
//  in_byte        in   8      host data byte; stable while in_strobe is high
//  in_strobe      in   1      host strobe, asynchronous to clk; each rising edge = one tick
//  out_byte       out  8      current result byte, MSB byte first
//  busy           out  1      high in ISSUE and WAIT
//  done           out  1      high throughout DRAIN after a valid result
//  err            out  1      high throughout DRAIN after a timeout
//  mul_a_bits     out  WIDTH  operand A to multiplier
//  mul_a_valid    out  1      one-cycle issue pulse
//  mul_b_bits     out  WIDTH  operand B to multiplier
//  mul_b_valid    out  1      same cycle as mul_a_valid
//  mul_out_valid  in   1      multiplier result valid
//  mul_out_bits   in   WIDTH  multiplier result
// BEHAVIOUR
//  Reset values (all outputs): 0. State resets to LOAD_A; byte count and timer reset to 0.
//  Tick generation:
//  - in_strobe passes through SYNC_STAGES flops.
//  - tick = synced & ~synced_d (one cycle, SYNC_STAGES+1 cycles after the pin rises).
//  - in_byte is sampled on tick with no synchronizer; host holds it stable while strobe is high.
//  States and transitions:
//  - LOAD_A: each tick does a <= {a[WIDTH-9:0], in_byte}, cnt++.
//    At cnt == NBYTES-1 with a tick: cnt <= 0, go to LOAD_B.
//  - LOAD_B: same, shifting into b; at the final byte go to ISSUE.
//  - ISSUE: mul_a_valid = mul_b_valid = 1 for exactly this cycle; timer <= 0; go to WAIT.
//  - WAIT: timer++ each cycle.
//    - mul_out_valid = 1: res <= mul_out_bits, done <= 1, go to DRAIN.
//    - Else if timer == TIMEOUT-1: res <= 0, err <= 1, go to DRAIN.
//    - If both happen in the same cycle, the valid result wins.
//  - DRAIN: out_byte = res[WIDTH-1 -: 8] at all times.
//    - Each tick: res <= res << 8, cnt++.
//    - The tick consuming the last byte sets cnt <= 0, clears done and err, and goes to LOAD_A.
//  Operand hold:
//  - mul_a_bits/mul_b_bits are the a/b registers; they change only in LOAD_A/LOAD_B.
//  - They stay stable through ISSUE, WAIT and DRAIN.
//  Ignored events (dropped, with no counter or state effect):
//  - Ticks in ISSUE and WAIT.
//  - mul_out_valid in any state other than WAIT.
//  Reset mid-operation: everything clears immediately, including partial operands and a pending result.
//  Latency: ISSUE is 1 cycle after the last B tick; DRAIN is 1 cycle after mul_out_valid.
// STRUCTURE
//  Package fmul_bridge_pkg:
//  - state enum {LOAD_A, LOAD_B, ISSUE, WAIT, DRAIN}
//  - localparam NBYTES
//  - width-derived counter/timer widths: $clog2(NBYTES), $clog2(TIMEOUT+1)
//  Sub-module strobe_sync_edge (SYNC_STAGES): async-reset synchronizer plus rising-edge detect; output tick.
//  Top holds the FSM, shift registers a/b/res, byte counter and timeout timer.
// TESTING (bench uses a behavioural multiplier model with programmable latency)
//  1. Bytes 40 00 00 00, 40 00 00 00; model returns 40800000 after 3 cycles
//     -> one mul_a/b_valid pulse; done=1; four ticks read 40,80,00,00.
//  2. Model never responds
//     -> err=1 exactly TIMEOUT cycles after ISSUE; drained bytes 00,00,00,00; then LOAD_A.
//  3. Extra strobes during WAIT, plus mul_out_valid pulses during LOAD_A
//     -> both ignored; operands and final result unchanged.
//  4. rst_n low after 2 bytes of B
//     -> all outputs 0, state LOAD_A; next 8 bytes 3F800000, C0000000 form a fresh pair.
//  5. Back-to-back transactions (case 1, then 3F800000 x C0000000 -> C0000000)
//     -> each issues exactly one valid pulse; drain reads C0,00,00,00.
//  6. Strobe pulse shorter than 1 clk and strobe held high for many cycles
//     -> a held strobe yields exactly one tick; a sub-cycle glitch yields at most one.

Source files
------------

// File: rtl/fmul_bridge_pkg.sv
// Shared types and sizing helpers for the byte-wide float multiplier bridge.
package fmul_bridge_pkg;

    typedef enum logic [2:0] {LOAD_A, LOAD_B, ISSUE, WAIT, DRAIN} state_t;

    localparam int WIDTH_DFLT   = 32;
    localparam int TIMEOUT_DFLT = 255;
    localparam int NBYTES       = WIDTH_DFLT / 8;

    // Counter width that still holds at least one bit for degenerate sizes.
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W = ctr_width(NBYTES);
    localparam int TMR_W = ctr_width(TIMEOUT_DFLT + 1);

endpackage

// File: rtl/strobe_sync_edge.sv
// Brings the asynchronous host strobe into clk and emits a one-cycle tick per rising edge.
module strobe_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            synced_d <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], strobe};
            synced_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~synced_d;

endmodule

// File: rtl/fmul_byte_bridge.sv
// Loads two operands a byte at a time, issues them to the multiplier, and drains the result bytewise.
//
//  state  | meaning
//  LOAD_A | shifting host bytes into operand A
//  LOAD_B | shifting host bytes into operand B
//  ISSUE  | one-cycle valid pulse to the multiplier
//  WAIT   | waiting for the result or the timeout
//  DRAIN  | host reads the result MSB byte first
module fmul_byte_bridge
    import fmul_bridge_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_byte,
    input  logic             in_strobe,
    output logic [7:0]       out_byte,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mul_a_bits,
    output logic             mul_a_valid,
    output logic [WIDTH-1:0] mul_b_bits,
    output logic             mul_b_valid,
    input  logic             mul_out_valid,
    input  logic [WIDTH-1:0] mul_out_bits
);

    localparam int NB = WIDTH / 8;
    localparam int CW = ctr_width(NB);
    localparam int TW = ctr_width(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res;
    logic             tick;

    strobe_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (in_strobe),
        .tick   (tick)
    );

    assign mul_a_bits = a_q;
    assign mul_b_bits = b_q;
    assign out_byte   = res[WIDTH-1 -: 8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD_A;
            cnt         <= '0;
            timer       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            mul_a_valid <= 1'b0;
            mul_b_valid <= 1'b0;
        end else begin
            mul_a_valid <= 1'b0;
            mul_b_valid <= 1'b0;
            case (state)
                LOAD_A: begin
                    if (tick) begin
                        a_q <= (a_q << 8) | WIDTH'(in_byte);
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (tick) begin
                        b_q <= (b_q << 8) | WIDTH'(in_byte);
                        if (cnt == CNT_LAST) begin
                            cnt         <= '0;
                            state       <= ISSUE;
                            busy        <= 1'b1;
                            mul_a_valid <= 1'b1;
                            mul_b_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // A result arriving on the timeout cycle still counts as valid.
                    if (mul_out_valid) begin
                        res   <= mul_out_bits;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DRAIN;
                    end else if (timer == TMR_LAST) begin
                        res   <= '0;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tick) begin
                        res <= res << 8;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            done  <= 1'b0;
                            err   <= 1'b0;
                            state <= LOAD_A;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_byte_bridge.sv
// Randomized bench for fmul_byte_bridge against a transaction-level model with a programmable-latency multiplier.
module tb_fmul_byte_bridge;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_strobe = 1'b0;
    logic [7:0]  out_byte;
    logic        busy, done, err;
    logic [31:0] mul_a_bits, mul_b_bits;
    logic        mul_a_valid, mul_b_valid;
    logic        mul_out_valid = 1'b0;
    logic [31:0] mul_out_bits = 32'h0;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    fmul_byte_bridge #(.WIDTH(32), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_byte       (in_byte),
        .in_strobe     (in_strobe),
        .out_byte      (out_byte),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mul_a_bits    (mul_a_bits),
        .mul_a_valid   (mul_a_valid),
        .mul_b_bits    (mul_b_bits),
        .mul_b_valid   (mul_b_valid),
        .mul_out_valid (mul_out_valid),
        .mul_out_bits  (mul_out_bits)
    );

    always @(posedge clk) if (mul_a_valid === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Single-precision multiply for normal operands, truncating the mantissa.
    function automatic logic [31:0] fmul_ref(input logic [31:0] x, input logic [31:0] y);
        logic [47:0] p;
        int          e;
        logic        s;
        s = x[31] ^ y[31];
        if (x[30:0] == 31'h0 || y[30:0] == 31'h0) return {s, 31'h0};
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e = int'(x[30:23]) + int'(y[30:23]) - 127;
        if (p[47]) return {s, 8'(e + 1), p[46:24]};
        return {s, 8'(e), p[45:23]};
    endfunction

    function automatic logic [31:0] rand_float();
        return {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        in_byte   = b;
        in_strobe = 1'b1;
        cyc(hold);
        in_strobe = 1'b0;
        cyc(4);
    endtask

    // Sub-cycle pulse placed across a rising clock edge.
    task automatic glitch_byte(input logic [7:0] b);
        @(negedge clk);
        in_byte = b;
        #4 in_strobe = 1'b1;
        #2 in_strobe = 1'b0;
        cyc(6);
    endtask

    task automatic pulse_result(input logic [31:0] r);
        mul_out_bits  = r;
        mul_out_valid = 1'b1;
        cyc(1);
        mul_out_valid = 1'b0;
    endtask

    // mode 1: second A byte held for many cycles, third A byte sent as a glitch.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int lat,
                           input bit respond, input bit noisy, input int mode);
        logic [31:0] exp_res;
        int          n, w, p0;
        p0 = pulse_cnt;
        if (noisy) pulse_result(32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            if (mode == 1 && i == 1) send_byte(a[31-8*i -: 8], 50);
            else if (mode == 1 && i == 2) glitch_byte(a[31-8*i -: 8]);
            else send_byte(a[31-8*i -: 8], 4);
            if (noisy && i == 1) pulse_result(32'h12345678);
        end
        for (int i = 0; i < 3; i++) send_byte(b[31-8*i -: 8], 4);
        in_byte   = b[7:0];
        in_strobe = 1'b1;
        n = 0;
        while (mul_a_valid !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
            if (n == 4) in_strobe = 1'b0;
        end
        in_strobe = 1'b0;
        check("issue_seen", {31'h0, mul_a_valid}, 32'h1);
        check("issue_b_valid", {31'h0, mul_b_valid}, 32'h1);
        check("issue_busy", {31'h0, busy}, 32'h1);
        check("operand_a", mul_a_bits, a);
        check("operand_b", mul_b_bits, b);
        if (respond) begin
            exp_res = fmul_ref(a, b);
            if (noisy) begin
                send_byte(8'hFF, 4);
                send_byte(8'hEE, 4);
                cyc(lat - 17);
            end else begin
                cyc(lat - 1);
            end
            check("wait_busy", {30'h0, busy, done}, 32'h2);
            pulse_result(exp_res);
            check("done_latency", {29'h0, done, err, busy}, 32'h4);
        end else begin
            exp_res = 32'h0;
            n = 0;
            w = 0;
            while (err !== 1'b1 && n < TIMEOUT + 50) begin
                cyc(1);
                n++;
                if (busy === 1'b1 && err !== 1'b1) w++;
            end
            check("timeout_cycles", w, TIMEOUT);
            check("timeout_flags", {29'h0, done, err, busy}, 32'h2);
        end
        check("one_issue_pulse", pulse_cnt - p0, 32'd1);
        check("hold_a", mul_a_bits, a);
        check("hold_b", mul_b_bits, b);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_byte%0d", i), {24'h0, out_byte}, {24'h0, exp_res[31-8*i -: 8]});
            check("drain_flag", {30'h0, done, err}, respond ? 32'h2 : 32'h1);
            send_byte(8'h00, 4);
        end
        check("after_drain", {24'h0, out_byte, 5'h0, busy, done, err}, 32'h0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        cyc(2);
        check("reset_outs", {24'h0, out_byte, 3'h0, mul_a_valid, mul_b_valid, busy, done, err}, 32'h0);
        check("reset_a", mul_a_bits, 32'h0);
        check("reset_b", mul_b_bits, 32'h0);
        rst_n = 1'b1;
        cyc(2);

        run_txn(32'h40000000, 32'h40000000, 3, 1'b1, 1'b0, 0);
        run_txn(32'h3F800000, 32'h40400000, 1, 1'b0, 1'b0, 0);
        run_txn(32'h3FC00000, 32'h40A00000, 25, 1'b1, 1'b1, 0);

        for (int i = 0; i < 4; i++) send_byte(8'h11 * 8'(i + 1), 4);
        send_byte(8'hAB, 4);
        send_byte(8'hCD, 4);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_outs", {24'h0, out_byte, 3'h0, mul_a_valid, mul_b_valid, busy, done, err}, 32'h0);
        check("midrst_a", mul_a_bits, 32'h0);
        check("midrst_b", mul_b_bits, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        run_txn(32'h3F800000, 32'hC0000000, 4, 1'b1, 1'b0, 0);

        run_txn(32'h40000000, 32'h40000000, 3, 1'b1, 1'b0, 0);
        run_txn(32'h3F800000, 32'hC0000000, 2, 1'b1, 1'b0, 0);

        run_txn(32'h41200000, 32'h3E800000, 5, 1'b1, 1'b0, 1);

        for (int i = 0; i < 6; i++) begin
            ra = rand_float();
            rb = rand_float();
            run_txn(ra, rb, int'($urandom_range(1, 30)), 1'b1, 1'b0, 0);
        end
        ra = rand_float();
        rb = rand_float();
        run_txn(ra, rb, int'($urandom_range(20, 40)), 1'b1, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
